// File: rtl/up_down_count_scheduler_if.sv
// up_down_count_scheduler_if: job handshakes from two clients plus counter status outputs.
interface up_down_count_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_target;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_target;
    logic             req1_ready;
    logic             abort;
    logic [WIDTH-1:0] counter;
    logic             up;
    logic             busy;
    logic             done;
    logic             done_id;
    modport master (
        output req0_valid, req0_target, req1_valid, req1_target, abort,
        input  req0_ready, req1_ready, counter, up, busy, done, done_id
    );
    modport slave (
        input  req0_valid, req0_target, req1_valid, req1_target, abort,
        output req0_ready, req1_ready, counter, up, busy, done, done_id
    );
endinterface

// File: rtl/up_down_count_scheduler.sv
// up_down_count_scheduler: round-robin two-client scheduler stepping a shared up/down counter to job targets.
// Define WRAP_SHORTEST_EN to step along the shortest modular path instead of the direct unsigned one.
module up_down_count_scheduler #(
    parameter int WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    up_down_count_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] step;
    logic             id;
    logic             last;
    logic             grant0;
    logic             grant1;
    logic             take0;
    logic             take1;
    logic             dir;
    // Ties go to whichever client was not granted last.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
    assign bus.req0_ready = rst_n & (state == IDLE) & grant0 & ~bus.abort;
    assign bus.req1_ready = rst_n & (state == IDLE) & grant1 & ~bus.abort;
    assign take0 = bus.req0_ready & bus.req0_valid;
    assign take1 = bus.req1_ready & bus.req1_valid;
    assign pick = take1 ? bus.req1_target : bus.req0_target;
    assign step = bus.up ? bus.counter + 1'b1 : bus.counter - 1'b1;
    assign bus.busy = state != IDLE;
`ifdef WRAP_SHORTEST_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] d_up;
    assign d_up = pick - bus.counter;
    assign dir = d_up <= HALF;
`else
    assign dir = pick > bus.counter;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.counter <= '0;
            bus.up      <= 1'b1;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            last        <= 1'b1;
            target      <= '0;
            id          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (take0 | take1) begin
                    target <= pick;
                    id     <= take1;
                    last   <= take1;
                    bus.up <= dir;
                    state  <= (pick == bus.counter) ? DONE : RUN;
                    if (pick == bus.counter) begin
                        bus.done    <= 1'b1;
                        bus.done_id <= take1;
                    end
                end
                RUN: if (bus.abort) begin
                    state <= IDLE;
                end else begin
                    bus.counter <= step;
                    if (step == target) begin
                        state       <= DONE;
                        bus.done    <= 1'b1;
                        bus.done_id <= id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_up_down_count_scheduler.sv
// tb_up_down_count_scheduler: directed jobs checked against a job-level model every cycle plus literal expectations.
module tb_up_down_count_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    up_down_count_scheduler_if #(.WIDTH(4)) bus ();
    up_down_count_scheduler #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int   m_count = 0;
    int   m_left = 0;
    logic m_up = 1'b1;
    logic m_active = 1'b0;
    logic m_donephase = 1'b0;
    logic m_done_id = 1'b0;
    logic m_last = 1'b1;
    logic m_id = 1'b0;
    logic exp_r0, exp_r1, m_idle, job_up;
    logic [3:0] sel_t;
    int   job_n;

    assign m_idle = !m_active && !m_donephase;
    assign exp_r0 = rst_n && m_idle && !bus.abort && bus.req0_valid && (!bus.req1_valid || m_last);
    assign exp_r1 = rst_n && m_idle && !bus.abort && bus.req1_valid && (!bus.req0_valid || !m_last);

    // A job is just a direction and a number of steps worked out from the distance.
    always_comb begin
        sel_t = exp_r1 ? bus.req1_target : bus.req0_target;
`ifdef WRAP_SHORTEST_EN
        job_n = (int'(sel_t) - m_count) & 15;
        job_up = job_n <= 8;
        if (!job_up) job_n = 16 - job_n;
`else
        job_up = int'(sel_t) > m_count;
        job_n = job_up ? int'(sel_t) - m_count : m_count - int'(sel_t);
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 0;
            m_left <= 0;
            m_up <= 1'b1;
            m_active <= 1'b0;
            m_donephase <= 1'b0;
            m_done_id <= 1'b0;
            m_last <= 1'b1;
            m_id <= 1'b0;
        end else if (m_active) begin
            if (bus.abort) begin
                m_active <= 1'b0;
            end else begin
                m_count <= (m_count + (m_up ? 1 : 15)) % 16;
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_active <= 1'b0;
                    m_donephase <= 1'b1;
                    m_done_id <= m_id;
                end
            end
        end else if (m_donephase) begin
            m_donephase <= 1'b0;
        end else if (exp_r0 || exp_r1) begin
            m_id <= exp_r1;
            m_last <= exp_r1;
            m_up <= job_up;
            if (job_n == 0) begin
                m_donephase <= 1'b1;
                m_done_id <= exp_r1;
            end else begin
                m_active <= 1'b1;
                m_left <= job_n;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("m_counter", bus.counter, m_count);
        chk("m_up", bus.up, m_up);
        chk("m_busy", bus.busy, m_active | m_donephase);
        chk("m_done", bus.done, m_donephase);
        chk("m_done_id", bus.done_id, m_done_id);
        chk("m_ready0", bus.req0_ready, exp_r0);
        chk("m_ready1", bus.req1_ready, exp_r1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise valid, wait for the grant, let the handshake edge pass, drop valid.
    task automatic submit(input logic c, input logic [3:0] t);
        int k = 0;
        if (c) begin
            bus.req1_valid = 1'b1;
            bus.req1_target = t;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_target = t;
        end
        #1;
        while (!(c ? bus.req1_ready : bus.req0_ready) && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("grant_in_time", k < 40, 1);
        @(negedge clk);
        if (c) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_n, input logic exp_id, input logic [3:0] exp_cnt);
        int k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("steps_to_done", k, exp_n);
        chk("done_id", bus.done_id, exp_id);
        chk("done_counter", bus.counter, exp_cnt);
        chk("done_busy", bus.busy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_target = 4'd5;
        bus.req1_valid = 1'b0;
        bus.req1_target = 4'd0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("rst_counter", bus.counter, 0);
        chk("rst_up", bus.up, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready0_after_rst", bus.req0_ready, 1);
        // Simple count 0 -> 5.
        submit(1'b0, 4'd5);
        chk("t1_up", bus.up, 1);
        chk("t1_busy", bus.busy, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t1_step", bus.counter, i);
            chk("t1_no_done", bus.done, 0);
        end
        wait_done(1, 1'b0, 4'd5);
        @(negedge clk);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_done_low", bus.done, 0);
        // Both clients at once: client 0 first, then client 1, then client 0 again.
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_target = 4'd3;
        bus.req1_valid = 1'b1;
        bus.req1_target = 4'd1;
        #1;
        chk("t2_ready0", bus.req0_ready, 1);
        chk("t2_ready1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        wait_done(3, 1'b0, 4'd3);
        @(negedge clk);
        #1 chk("t2_ready1_next", bus.req1_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        chk("t2_down", bus.up, 0);
        wait_done(2, 1'b1, 4'd1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("t2_ready0_again", bus.req0_ready, 1);
        chk("t2_ready1_again", bus.req1_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        // Zero-distance job.
        submit(1'b0, 4'd7);
        wait_done(6, 1'b0, 4'd7);
        @(negedge clk);
        submit(1'b1, 4'd7);
        wait_done(0, 1'b1, 4'd7);
        @(negedge clk);
        chk("t3_done_one_cycle", bus.done, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_done_id_hold", bus.done_id, 1);
        // Abort mid-run, abort blocking acceptance in idle, then resume.
        do_reset();
        submit(1'b0, 4'd9);
        repeat (4) @(negedge clk);
        chk("t4_at_4", bus.counter, 4);
        bus.abort = 1'b1;
        @(negedge clk);
        chk("t4_abort_hold", bus.counter, 4);
        chk("t4_abort_idle", bus.busy, 0);
        chk("t4_abort_no_done", bus.done, 0);
        bus.req0_valid = 1'b1;
        bus.req0_target = 4'd2;
        #1 chk("t4_abort_blocks", bus.req0_ready, 0);
        @(negedge clk);
        chk("t4_still_4", bus.counter, 4);
        bus.abort = 1'b0;
        submit(1'b0, 4'd6);
        wait_done(2, 1'b0, 4'd6);
        @(negedge clk);
        // Long way round vs. wrap.
        do_reset();
        submit(1'b0, 4'd1);
        wait_done(1, 1'b0, 4'd1);
        @(negedge clk);
        submit(1'b0, 4'd14);
`ifdef WRAP_SHORTEST_EN
        chk("t5_up", bus.up, 0);
        wait_done(3, 1'b0, 4'd14);
`else
        chk("t5_up", bus.up, 1);
        wait_done(13, 1'b0, 4'd14);
`endif
        @(negedge clk);
        // Asynchronous reset in the middle of a run.
        do_reset();
        submit(1'b0, 4'd3);
        wait_done(3, 1'b0, 4'd3);
        @(negedge clk);
        submit(1'b1, 4'd8);
        chk("t6_mid_run", bus.counter, 3);
        bus.req0_valid = 1'b1;
        bus.req0_target = 4'd2;
        bus.req1_valid = 1'b1;
        bus.req1_target = 4'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_counter", bus.counter, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_up", bus.up, 1);
        chk("t6_ready0", bus.req0_ready, 0);
        chk("t6_ready1", bus.req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_tie_ready0", bus.req0_ready, 1);
        chk("t6_tie_ready1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_done(2, 1'b0, 4'd2);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
